// File: rtl/pc_next_ctrl.sv
// Next-PC control stage: decodes JMP/BRZ/BRNZ/CALL/RET, drives the PC load
// value (PCIN) and load strobe (z), and keeps a return-address stack (RAS)
// with sticky overflow/underflow flags.
// Optional build macro PC_NEXT_CTRL_RAS_WRAP_EN makes the RAS circular: a CALL
// on a full stack overwrites the oldest entry instead of being refused.
module pc_next_ctrl #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [AW-1:0]                  PC,
    input  logic [2:0]                     op,
    input  logic [AW-1:0]                  target,
    input  logic                           zero,
    input  logic                           clr_err,
    output logic [AW-1:0]                  PCIN,
    output logic                           z,
    output logic [$clog2(DEPTH+1)-1:0]     depth,
    output logic                           ovf,
    output logic                           unf,
    output logic                           taken_q
);

    localparam int unsigned DW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    localparam logic [2:0] OpJmp  = 3'd1;
    localparam logic [2:0] OpBrz  = 3'd2;
    localparam logic [2:0] OpBrnz = 3'd3;
    localparam logic [2:0] OpCall = 3'd4;
    localparam logic [2:0] OpRet  = 3'd5;

    // RAS is addressed through a write pointer (next free slot) so that the
    // same storage works as a plain stack or as a circular buffer.
    logic [AW-1:0] ras_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] top_ptr;
    logic [PW-1:0] nxt_ptr;
    logic [DW-1:0] depth_q;
    logic          ovf_q;
    logic          unf_q;

    logic [AW-1:0] pc_inc;
    logic [AW-1:0] br_tgt;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          set_ovf;
    logic          set_unf;

    // Shared address arithmetic; adding the AW-bit offset at AW width is the
    // same as sign-extending it, modulo 2^AW.
    always_comb begin
        pc_inc  = PC + AW'(1);
        br_tgt  = PC + target;
        full    = (depth_q == DW'(DEPTH));
        empty   = (depth_q == '0);
        top_ptr = (wr_ptr_q == '0) ? PW'(DEPTH - 1) : wr_ptr_q - PW'(1);
        nxt_ptr = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    end

    // Op decode: next-PC value, load strobe and RAS/flag actions.
    always_comb begin
        PCIN    = pc_inc;
        z       = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        case (op)
            OpJmp: begin
                z    = 1'b1;
                PCIN = target;
            end
            OpBrz: begin
                if (zero) begin
                    z    = 1'b1;
                    PCIN = br_tgt;
                end
            end
            OpBrnz: begin
                if (!zero) begin
                    z    = 1'b1;
                    PCIN = br_tgt;
                end
            end
            OpCall: begin
                if (!full) begin
                    z    = 1'b1;
                    PCIN = target;
                    push = 1'b1;
                end else begin
`ifdef PC_NEXT_CTRL_RAS_WRAP_EN
                    z       = 1'b1;
                    PCIN    = target;
                    push    = 1'b1;
                    set_ovf = 1'b1;
`else
                    set_ovf = 1'b1;
`endif
                end
            end
            OpRet: begin
                if (!empty) begin
                    z    = 1'b1;
                    PCIN = ras_q[top_ptr];
                    pop  = 1'b1;
                end else begin
                    set_unf = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Control state: depth, pointer, sticky flags (set beats clear) and the
    // delayed redirect indicator.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            depth_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            taken_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= nxt_ptr;
                if (!full) depth_q <= depth_q + DW'(1);
            end else if (pop) begin
                wr_ptr_q <= top_ptr;
                depth_q  <= depth_q - DW'(1);
            end
            if (set_ovf)      ovf_q <= 1'b1;
            else if (clr_err) ovf_q <= 1'b0;
            if (set_unf)      unf_q <= 1'b1;
            else if (clr_err) unf_q <= 1'b0;
            taken_q <= z;
        end
    end

    // RAS storage; contents need no reset.
    always_ff @(posedge clk) begin
        if (!reset && push) ras_q[wr_ptr_q] <= pc_inc;
    end

    assign depth = depth_q;
    assign ovf   = ovf_q;
    assign unf   = unf_q;

endmodule

// File: tb/tb_pc_next_ctrl.sv
// Bench for pc_next_ctrl: queue-based reference model checked every cycle,
// plus literal expectations from hand-worked cases.
module tb_pc_next_ctrl;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] PC;
    logic [2:0]    op;
    logic [AW-1:0] target;
    logic          zero;
    logic          clr_err;
    logic [AW-1:0] PCIN;
    logic          z;
    logic [3:0]    depth;
    logic          ovf;
    logic          unf;
    logic          taken_q;

    pc_next_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk     (clk),
        .reset   (reset),
        .PC      (PC),
        .op      (op),
        .target  (target),
        .zero    (zero),
        .clr_err (clr_err),
        .PCIN    (PCIN),
        .z       (z),
        .depth   (depth),
        .ovf     (ovf),
        .unf     (unf),
        .taken_q (taken_q)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model state
    logic [AW-1:0] ras_m[$];
    bit            m_ovf, m_unf, m_taken;
    // Expected combinational outputs for the current cycle
    logic [AW-1:0] e_pcin;
    bit            e_z;
    // Effects of the current cycle, applied at the next posedge
    bit            p_rst, p_push, p_pop, p_sovf, p_sunf, p_clr;
    logic [AW-1:0] p_val;
    bit            chk_en = 0;

    function automatic void model_apply();
        if (p_rst) begin
            ras_m.delete();
            m_ovf   = 0;
            m_unf   = 0;
            m_taken = 0;
        end else begin
            if (p_push) begin
                if (ras_m.size() == DEPTH) void'(ras_m.pop_front());
                ras_m.push_back(p_val);
            end
            if (p_pop) void'(ras_m.pop_back());
            if (p_sovf) m_ovf = 1;
            else if (p_clr) m_ovf = 0;
            if (p_sunf) m_unf = 1;
            else if (p_clr) m_unf = 0;
            m_taken = e_z;
        end
    endfunction

    function automatic void model_eval(bit rst, logic [2:0] o, logic [AW-1:0] pc,
                                       logic [AW-1:0] tg, bit zr, bit clr);
        logic [AW-1:0] ret_addr;
        logic [AW-1:0] br;
        bit            wrap_ok;
        ret_addr = pc + 8'd1;
        br       = pc + tg;
`ifdef PC_NEXT_CTRL_RAS_WRAP_EN
        wrap_ok = 1;
`else
        wrap_ok = 0;
`endif
        e_pcin = ret_addr;
        e_z    = 0;
        p_rst  = rst;
        p_push = 0;
        p_pop  = 0;
        p_sovf = 0;
        p_sunf = 0;
        p_clr  = clr;
        p_val  = ret_addr;
        if (o == 3'd1) begin
            e_z = 1; e_pcin = tg;
        end else if ((o == 3'd2 && zr) || (o == 3'd3 && !zr)) begin
            e_z = 1; e_pcin = br;
        end else if (o == 3'd4) begin
            if (ras_m.size() < DEPTH || wrap_ok) begin
                e_z = 1; e_pcin = tg; p_push = 1;
            end
            if (ras_m.size() == DEPTH) p_sovf = 1;
        end else if (o == 3'd5) begin
            if (ras_m.size() > 0) begin
                e_z = 1; e_pcin = ras_m[$]; p_pop = 1;
            end else begin
                p_sunf = 1;
            end
        end
    endfunction

    // One clock cycle: commit the previous cycle to the model, then drive.
    task automatic step(bit rst, logic [2:0] o, logic [AW-1:0] pc,
                        logic [AW-1:0] tg, bit zr, bit clr);
        @(posedge clk);
        if (chk_en) model_apply();
        #1;
        reset = rst; op = o; PC = pc; target = tg; zero = zr; clr_err = clr;
        model_eval(rst, o, pc, tg, zr, clr);
        chk_en = 1;
        #2;
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("pcin", 32'(PCIN), 32'(e_pcin));
            chk("z", 32'(z), 32'(e_z));
            chk("depth", 32'(depth), 32'(ras_m.size()));
            chk("ovf", 32'(ovf), 32'(m_ovf));
            chk("unf", 32'(unf), 32'(m_unf));
            chk("taken_q", 32'(taken_q), 32'(m_taken));
        end
    end

    initial begin
        reset = 1; op = 0; PC = 8'hFF; target = 0; zero = 0; clr_err = 0;
        step(1, 3'd0, 8'hFF, 8'h00, 0, 0);
        step(1, 3'd0, 8'hFF, 8'h00, 0, 0);
        chk("lit_rst_pcin", 32'(PCIN), 32'h00);
        chk("lit_rst_z", 32'(z), 32'h0);

        step(0, 3'd0, 8'h10, 8'h00, 0, 0);
        chk("lit_none_pcin", 32'(PCIN), 32'h11);
        chk("lit_none_state", {28'd0, depth}, 32'h0);
        chk("lit_none_flags", {29'd0, ovf, unf, taken_q}, 32'h0);

        step(0, 3'd2, 8'h05, 8'hFE, 1, 0);
        chk("lit_brz_pcin", 32'(PCIN), 32'h03);
        chk("lit_brz_z", 32'(z), 32'h1);
        step(0, 3'd2, 8'h05, 8'hFE, 0, 0);
        chk("lit_brz0_pcin", 32'(PCIN), 32'h06);
        chk("lit_brz_taken", 32'(taken_q), 32'h1);

        step(0, 3'd1, 8'hFF, 8'h00, 0, 0);
        chk("lit_jmp_wrap", 32'(PCIN), 32'h00);
        step(0, 3'd3, 8'hFF, 8'h02, 0, 0);
        chk("lit_brnz_wrap", 32'(PCIN), 32'h01);

        step(0, 3'd4, 8'h20, 8'h80, 0, 0);
        chk("lit_call_pcin", 32'(PCIN), 32'h80);
        step(0, 3'd5, 8'h85, 8'h00, 0, 0);
        chk("lit_ret_pcin", 32'(PCIN), 32'h21);
        chk("lit_ret_depth", 32'(depth), 32'h1);
        step(0, 3'd0, 8'h86, 8'h00, 0, 0);
        chk("lit_after_ret_depth", 32'(depth), 32'h0);

        for (int i = 0; i < DEPTH; i++) step(0, 3'd4, 8'(i), 8'(8'h40 + i), 0, 0);
        step(0, 3'd4, 8'h30, 8'h90, 0, 0);
`ifdef PC_NEXT_CTRL_RAS_WRAP_EN
        chk("lit_ovf_pcin", 32'(PCIN), 32'h90);
`else
        chk("lit_ovf_pcin", 32'(PCIN), 32'h31);
`endif
        step(0, 3'd0, 8'h31, 8'h00, 0, 0);
        chk("lit_ovf_flag", 32'(ovf), 32'h1);
        chk("lit_ovf_depth", 32'(depth), 32'h8);
        step(0, 3'd5, 8'h50, 8'h00, 0, 0);
`ifdef PC_NEXT_CTRL_RAS_WRAP_EN
        chk("lit_first_ret", 32'(PCIN), 32'h31);
`else
        chk("lit_first_ret", 32'(PCIN), 32'h08);
`endif
        for (int i = 1; i < DEPTH; i++) step(0, 3'd5, 8'h50, 8'h00, 0, 0);

        step(0, 3'd5, 8'h40, 8'h00, 0, 0);
        chk("lit_unf_pcin", 32'(PCIN), 32'h41);
        chk("lit_unf_z", 32'(z), 32'h0);
        step(0, 3'd5, 8'h40, 8'h00, 0, 1);
        step(0, 3'd0, 8'h40, 8'h00, 0, 1);
        chk("lit_unf_set_wins", 32'(unf), 32'h1);
        step(0, 3'd0, 8'h41, 8'h00, 0, 0);
        chk("lit_unf_cleared", 32'(unf), 32'h0);

        for (int i = 0; i < 3; i++) step(0, 3'd4, 8'(8'h60 + i), 8'h70, 0, 0);
        step(1, 3'd0, 8'hFF, 8'h00, 0, 0);
        chk("lit_rst_depth3", 32'(depth), 32'h3);
        step(0, 3'd0, 8'h00, 8'h00, 0, 0);
        chk("lit_rst_cleared", 32'(depth), 32'h0);

        for (int i = 6; i < 8; i++) step(0, 3'(i), 8'h12, 8'h34, 1, 0);
        step(0, 3'd0, 8'h00, 8'h00, 0, 0);
        @(posedge clk);
        #1;
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
